// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR test monitor: traffic-master state codes,
// monitor FSM encoding and counter widths.
package ddr_test_pkg;

    // Traffic-master state codes as driven on I_machine
    localparam logic [2:0] MS_IDLE       = 3'd0;
    localparam logic [2:0] MS_WRITE_ADDR = 3'd1;
    localparam logic [2:0] MS_WRITE_DATA = 3'd2;
    localparam logic [2:0] MS_WRITE_RESP = 3'd3;
    localparam logic [2:0] MS_READ_ADDR  = 3'd4;
    localparam logic [2:0] MS_READ_DATA  = 3'd5;
    localparam logic [2:0] MS_SET_IDLE   = 3'd6;

    // Monitor FSM encoding (visible on O_mon_state)
    localparam logic [1:0] MON_IDLE = 2'd0;
    localparam logic [1:0] MON_RUN  = 2'd1;
    localparam logic [1:0] MON_FAIL = 2'd2;
    localparam logic [1:0] MON_HANG = 2'd3;

    // Counter widths
    localparam int CNT_W   = 32;  // pass / fail / first-fail index
    localparam int BURST_W = 24;  // per-window burst accumulators
    localparam int WIN_W   = 32;  // window position counter
    localparam int WDOG_W  = 32;  // watchdog stall counter

endpackage

// File: rtl/ddr_mon_window_cnt.sv
// Free-running performance window: counts AW/AR handshakes over WIN_CYCLES
// clocks and publishes the totals of each completed window with a one-cycle
// valid pulse. A clear or reset restarts the window from position 0.
module ddr_mon_window_cnt
    import ddr_test_pkg::*;
#(
    parameter int WIN_CYCLES = 1000000
) (
    input  logic               I_aclk,
    input  logic               I_aresetn,
    input  logic               I_clear,
    input  logic               I_aw_hs,
    input  logic               I_ar_hs,
    output logic [BURST_W-1:0] O_wr_bursts,
    output logic [BURST_W-1:0] O_rd_bursts,
    output logic               O_win_valid
);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

    // Saturating increment: the accumulator sticks at all-ones
    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v,
                                                   input logic inc);
        if (inc && (v != {BURST_W{1'b1}}))
            return v + BURST_W'(1);
        return v;
    endfunction

    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [BURST_W-1:0] wr_acc_q, wr_acc_d;
    logic [BURST_W-1:0] rd_acc_q, rd_acc_d;
    logic [BURST_W-1:0] wr_out_q, wr_out_d;
    logic [BURST_W-1:0] rd_out_q, rd_out_d;
    logic               valid_q, valid_d;
    logic [BURST_W-1:0] wr_sum, rd_sum;

    // Next-state: advance window, accumulate, and publish on the last cycle
    always_comb begin
        wr_sum    = sat_inc(wr_acc_q, I_aw_hs);
        rd_sum    = sat_inc(rd_acc_q, I_ar_hs);
        win_cnt_d = win_cnt_q;
        wr_acc_d  = wr_acc_q;
        rd_acc_d  = rd_acc_q;
        wr_out_d  = wr_out_q;
        rd_out_d  = rd_out_q;
        valid_d   = 1'b0;
        if (I_clear) begin
            win_cnt_d = '0;
            wr_acc_d  = '0;
            rd_acc_d  = '0;
            wr_out_d  = '0;
            rd_out_d  = '0;
        end else if (win_cnt_q == WIN_LAST) begin
            // The last cycle's own handshake belongs to the window it closes
            win_cnt_d = '0;
            wr_acc_d  = '0;
            rd_acc_d  = '0;
            wr_out_d  = wr_sum;
            rd_out_d  = rd_sum;
            valid_d   = 1'b1;
        end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            wr_acc_d  = wr_sum;
            rd_acc_d  = rd_sum;
        end
    end

    // Window state registers
    always_ff @(posedge I_aclk or negedge I_aresetn) begin
        if (!I_aresetn) begin
            win_cnt_q <= '0;
            wr_acc_q  <= '0;
            rd_acc_q  <= '0;
            wr_out_q  <= '0;
            rd_out_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            wr_acc_q  <= wr_acc_d;
            rd_acc_q  <= rd_acc_d;
            wr_out_q  <= wr_out_d;
            rd_out_q  <= rd_out_d;
            valid_q   <= valid_d;
        end
    end

    assign O_wr_bursts = wr_out_q;
    assign O_rd_bursts = rd_out_q;
    assign O_win_valid = valid_q;

endmodule

// File: rtl/ddr_test_monitor.sv
// DDR traffic test monitor: pass/fail beat statistics, first-mismatch index,
// AW/AR burst throughput per window, optional stall watchdog and a small
// status FSM. The watchdog is built only when DDR_MON_HANG_EN is defined;
// otherwise O_hang is tied low and the HANG state is never entered.
module ddr_test_monitor
    import ddr_test_pkg::*;
#(
    parameter int WIN_CYCLES  = 1000000,
    parameter int HANG_CYCLES = 65536
) (
    input  logic               I_aclk,
    input  logic               I_aresetn,
    input  logic               I_clear,
    input  logic               I_cmp_result_en,
    input  logic               I_cmp_result,
    input  logic [2:0]         I_machine,
    input  logic               I_aw_hs,
    input  logic               I_ar_hs,
    output logic [CNT_W-1:0]   O_pass_cnt,
    output logic [CNT_W-1:0]   O_fail_cnt,
    output logic [CNT_W-1:0]   O_first_fail_idx,
    output logic               O_fail,
    output logic [BURST_W-1:0] O_wr_bursts,
    output logic [BURST_W-1:0] O_rd_bursts,
    output logic               O_win_valid,
    output logic               O_hang,
    output logic [1:0]         O_mon_state
);

    // Both lengths must allow at least a two-cycle period
    if (WIN_CYCLES < 2 || HANG_CYCLES < 2) begin : g_bad_param
        $error("ddr_test_monitor: WIN_CYCLES and HANG_CYCLES must be >= 2");
    end

    // Saturating increment of a 32-bit statistic
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v != {CNT_W{1'b1}})
            return v + CNT_W'(1);
        return v;
    endfunction

    // Saturating sum used for the beat index (pass+fail may exceed 32 bits)
    function automatic logic [CNT_W-1:0] sat_sum(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CNT_W])
            return {CNT_W{1'b1}};
        return s[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             failf_q, failf_d;
    logic [1:0]       state_q, state_d;
    logic             mismatch;
    logic             activity;
    logic             hang_fire;

    assign mismatch = I_cmp_result_en && !I_cmp_result;
    assign activity = I_cmp_result_en || I_aw_hs || I_ar_hs;

    // Beat statistics and first-mismatch capture
    always_comb begin
        pass_d  = pass_q;
        fail_d  = fail_q;
        idx_d   = idx_q;
        failf_d = failf_q;
        if (I_clear) begin
            pass_d  = '0;
            fail_d  = '0;
            idx_d   = '0;
            failf_d = 1'b0;
        end else if (I_cmp_result_en) begin
            if (I_cmp_result) begin
                pass_d = sat_inc(pass_q);
            end else begin
                fail_d = sat_inc(fail_q);
                if (!failf_q) begin
                    idx_d   = sat_sum(pass_q, fail_q);
                    failf_d = 1'b1;
                end
            end
        end
    end

    // Statistics registers
    always_ff @(posedge I_aclk or negedge I_aresetn) begin
        if (!I_aresetn) begin
            pass_q  <= '0;
            fail_q  <= '0;
            idx_q   <= '0;
            failf_q <= 1'b0;
        end else begin
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            idx_q   <= idx_d;
            failf_q <= failf_d;
        end
    end

`ifdef DDR_MON_HANG_EN
    localparam logic [WDOG_W-1:0] HANG_LAST = WDOG_W'(HANG_CYCLES - 1);

    logic [2:0]        machine_q, machine_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              hang_q, hang_d;

    // Watchdog: count cycles of an unchanged, non-idle master with no strobe
    always_comb begin
        machine_d = I_machine;
        wdog_d    = wdog_q;
        hang_d    = hang_q;
        hang_fire = 1'b0;
        if (I_clear) begin
            machine_d = '0;
            wdog_d    = '0;
            hang_d    = 1'b0;
        end else begin
            if (I_machine == MS_IDLE || I_machine != machine_q || I_cmp_result_en)
                wdog_d = '0;
            else if (wdog_q != HANG_LAST)
                wdog_d = wdog_q + WDOG_W'(1);
            hang_fire = (wdog_d == HANG_LAST);
            hang_d    = hang_q | hang_fire;
        end
    end

    // Watchdog registers
    always_ff @(posedge I_aclk or negedge I_aresetn) begin
        if (!I_aresetn) begin
            machine_q <= '0;
            wdog_q    <= '0;
            hang_q    <= 1'b0;
        end else begin
            machine_q <= machine_d;
            wdog_q    <= wdog_d;
            hang_q    <= hang_d;
        end
    end

    assign O_hang = hang_q;
`else
    logic unused_machine;
    assign unused_machine = ^I_machine;
    assign hang_fire      = 1'b0;
    assign O_hang         = 1'b0;
`endif

    // Monitor FSM; a mismatch seen on the IDLE->RUN cycle is picked up from
    // the sticky flag one cycle later
    always_comb begin
        state_d = state_q;
        if (I_clear) begin
            state_d = MON_IDLE;
        end else begin
            case (state_q)
                MON_IDLE: if (activity) state_d = MON_RUN;
                MON_RUN: begin
                    if (hang_fire)
                        state_d = MON_HANG;
                    else if (mismatch || failf_q)
                        state_d = MON_FAIL;
                end
                MON_FAIL: if (hang_fire) state_d = MON_HANG;
                MON_HANG: state_d = MON_HANG;
                default:  state_d = MON_IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge I_aclk or negedge I_aresetn) begin
        if (!I_aresetn)
            state_q <= MON_IDLE;
        else
            state_q <= state_d;
    end

    ddr_mon_window_cnt #(
        .WIN_CYCLES (WIN_CYCLES)
    ) u_window (
        .I_aclk      (I_aclk),
        .I_aresetn   (I_aresetn),
        .I_clear     (I_clear),
        .I_aw_hs     (I_aw_hs),
        .I_ar_hs     (I_ar_hs),
        .O_wr_bursts (O_wr_bursts),
        .O_rd_bursts (O_rd_bursts),
        .O_win_valid (O_win_valid)
    );

    assign O_pass_cnt       = pass_q;
    assign O_fail_cnt       = fail_q;
    assign O_first_fail_idx = idx_q;
    assign O_fail           = failf_q;
    assign O_mon_state      = state_q;

endmodule

// File: tb/tb_ddr_test_monitor.sv
// Directed testbench for ddr_test_monitor (WIN_CYCLES=100, HANG_CYCLES=16).
module tb_ddr_test_monitor;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        clear = 1'b0;
    logic        en = 1'b0;
    logic        res = 1'b0;
    logic [2:0]  machine = 3'd0;
    logic        aw = 1'b0;
    logic        ar = 1'b0;
    logic [31:0] pass_cnt, fail_cnt, first_idx;
    logic        fail_flag, win_valid, hang;
    logic [23:0] wr_b, rd_b;
    logic [1:0]  mstate;

    int tests_run = 0;
    int tests_failed = 0;

    ddr_test_monitor #(
        .WIN_CYCLES  (100),
        .HANG_CYCLES (16)
    ) dut (
        .I_aclk           (clk),
        .I_aresetn        (aresetn),
        .I_clear          (clear),
        .I_cmp_result_en  (en),
        .I_cmp_result     (res),
        .I_machine        (machine),
        .I_aw_hs          (aw),
        .I_ar_hs          (ar),
        .O_pass_cnt       (pass_cnt),
        .O_fail_cnt       (fail_cnt),
        .O_first_fail_idx (first_idx),
        .O_fail           (fail_flag),
        .O_wr_bursts      (wr_b),
        .O_rd_bursts      (rd_b),
        .O_win_valid      (win_valid),
        .O_hang           (hang),
        .O_mon_state      (mstate)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear = 0; en = 0; res = 0; machine = 0; aw = 0; ar = 0;
        aresetn = 0;
        #2;
        aresetn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({pass_cnt, fail_cnt, first_idx, fail_flag, wr_b, rd_b, win_valid, hang, mstate} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got pass=%0d fail=%0d idx=%0d f=%0b wr=%0d rd=%0d v=%0b h=%0b st=%0d want all 0",
                     pass_cnt, fail_cnt, first_idx, fail_flag, wr_b, rd_b, win_valid, hang, mstate);
        end
        tick();
        tests_run++;
        if (mstate !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_idle_state got %0d want 0", mstate);
        end
    endtask

    task automatic test_pass_only();
        do_reset();
        en = 1; res = 1;
        for (int i = 0; i < 10; i++) tick();
        en = 0;
        tick();
        tests_run++;
        if (pass_cnt !== 32'd10) begin
            tests_failed++; $display("FAIL pass10_pass_cnt got %0d want 10", pass_cnt);
        end
        tests_run++;
        if (fail_cnt !== 32'd0) begin
            tests_failed++; $display("FAIL pass10_fail_cnt got %0d want 0", fail_cnt);
        end
        tests_run++;
        if (fail_flag !== 1'b0) begin
            tests_failed++; $display("FAIL pass10_fail_flag got %0b want 0", fail_flag);
        end
        tests_run++;
        if (mstate !== 2'd1) begin
            tests_failed++; $display("FAIL pass10_state got %0d want 1", mstate);
        end
    endtask

    task automatic test_first_fail();
        do_reset();
        en = 1; res = 1;
        for (int i = 0; i < 5; i++) tick();
        res = 0;
        tick();
        res = 1;
        for (int i = 0; i < 3; i++) tick();
        en = 0;
        tick();
        tests_run++;
        if (first_idx !== 32'd5) begin
            tests_failed++; $display("FAIL firstfail_idx got %0d want 5", first_idx);
        end
        tests_run++;
        if (fail_cnt !== 32'd1) begin
            tests_failed++; $display("FAIL firstfail_fail_cnt got %0d want 1", fail_cnt);
        end
        tests_run++;
        if (pass_cnt !== 32'd8) begin
            tests_failed++; $display("FAIL firstfail_pass_cnt got %0d want 8", pass_cnt);
        end
        tests_run++;
        if (fail_flag !== 1'b1) begin
            tests_failed++; $display("FAIL firstfail_flag got %0b want 1", fail_flag);
        end
        tests_run++;
        if (mstate !== 2'd2) begin
            tests_failed++; $display("FAIL firstfail_state got %0d want 2", mstate);
        end
    endtask

    task automatic test_window();
        int pulses;
        do_reset();
        pulses = 0;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 100; i++) begin
                aw = (i % 10 == 0);
                ar = (i == 99);
                tick();
                if (win_valid === 1'b1) pulses++;
                if (i == 99) begin
                    tests_run++;
                    if (win_valid !== 1'b1 || wr_b !== 24'd10 || rd_b !== 24'd1) begin
                        tests_failed++;
                        $display("FAIL window%0d_end got v=%0b wr=%0d rd=%0d want v=1 wr=10 rd=1",
                                 w, win_valid, wr_b, rd_b);
                    end
                end
            end
        end
        aw = 0; ar = 0;
        tests_run++;
        if (pulses != 2) begin
            tests_failed++; $display("FAIL window_pulse_count got %0d want 2", pulses);
        end
    endtask

    task automatic test_reset_mid_window();
        int pulses;
        // Leave published window totals from test_window, then dirty the counters
        en = 1; res = 1;
        for (int i = 0; i < 50; i++) begin
            aw = (i % 10 == 0);
            tick();
            en = 0;
        end
        aw = 0;
        #2;
        aresetn = 0;
        #1;
        tests_run++;
        if ({pass_cnt, fail_cnt, first_idx, fail_flag, wr_b, rd_b, win_valid, hang, mstate} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs got pass=%0d wr=%0d rd=%0d st=%0d v=%0b want all 0",
                     pass_cnt, wr_b, rd_b, mstate, win_valid);
        end
        #1;
        aresetn = 1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            aw = (i % 10 == 5);
            tick();
            if (i < 99 && win_valid === 1'b1) pulses++;
            if (i == 99) begin
                tests_run++;
                if (win_valid !== 1'b1 || wr_b !== 24'd10 || rd_b !== 24'd0) begin
                    tests_failed++;
                    $display("FAIL midreset_first_window got v=%0b wr=%0d rd=%0d want v=1 wr=10 rd=0",
                             win_valid, wr_b, rd_b);
                end
            end
        end
        aw = 0;
        tests_run++;
        if (pulses != 0) begin
            tests_failed++; $display("FAIL midreset_early_valid got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_hang();
        logic exp_hang;
`ifdef DDR_MON_HANG_EN
        exp_hang = 1'b1;
`else
        exp_hang = 1'b0;
`endif
        do_reset();
        machine = 3'd2;
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (hang !== 1'b0) begin
            tests_failed++; $display("FAIL hang_early got %0b want 0", hang);
        end
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (hang !== exp_hang) begin
            tests_failed++; $display("FAIL hang_machine2 got %0b want %0b", hang, exp_hang);
        end
        do_reset();
        machine = 3'd0;
        for (int i = 0; i < 20; i++) tick();
        tests_run++;
        if (hang !== 1'b0) begin
            tests_failed++; $display("FAIL hang_machine0 got %0b want 0", hang);
        end
    endtask

    task automatic test_clear();
        do_reset();
        en = 1; res = 1;
        for (int i = 0; i < 3; i++) tick();
        res = 0;
        tick();
        tick();
        tests_run++;
        if (fail_flag !== 1'b1 || mstate !== 2'd2) begin
            tests_failed++; $display("FAIL clear_setup got f=%0b st=%0d want f=1 st=2", fail_flag, mstate);
        end
        clear = 1; en = 1; res = 0;
        tick();
        tests_run++;
        if ({pass_cnt, fail_cnt, first_idx, fail_flag, mstate} !== '0) begin
            tests_failed++;
            $display("FAIL clear_all got pass=%0d fail=%0d idx=%0d f=%0b st=%0d want all 0",
                     pass_cnt, fail_cnt, first_idx, fail_flag, mstate);
        end
        clear = 0; en = 0;
        tick();
        tests_run++;
        if (pass_cnt !== 32'd0 || fail_cnt !== 32'd0 || mstate !== 2'd0) begin
            tests_failed++;
            $display("FAIL clear_after got pass=%0d fail=%0d st=%0d want 0 0 0", pass_cnt, fail_cnt, mstate);
        end
    endtask

    initial begin
        test_reset();
        test_pass_only();
        test_first_fail();
        test_window();
        test_reset_mid_window();
        test_hang();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
